// File: rtl/imm_pkg.sv
// Shared opcode constants and immediate-format codes for the immediate decode stage.
package imm_pkg;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6
   } imm_fmt_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational RISC-V immediate decode: picks the format from the opcode and
// extends the assembled immediate to WIDTH bits.
module imm_extract
   import imm_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [31:0]      instr,
   output logic [WIDTH-1:0] imm,
   output logic [2:0]       fmt,
   output logic             illegal
);

   logic [6:0] opcode;
   logic [31:0] raw;
   imm_fmt_e    fmt_e;

   assign opcode = instr[6:0];

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      raw   = '0;
      fmt_e = FMT_NONE;
      case (opcode)
         OP_IMM, OP_LOAD, OP_JALR: begin
            raw   = {{20{instr[31]}}, instr[31:20]};
            fmt_e = FMT_I;
         end
         OP_STORE: begin
            raw   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            fmt_e = FMT_S;
         end
         OP_BRANCH: begin
            raw   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            fmt_e = FMT_B;
         end
         OP_LUI, OP_AUIPC: begin
            raw   = {instr[31:12], 12'b0};
            fmt_e = FMT_U;
         end
         OP_JAL: begin
            raw   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            fmt_e = FMT_J;
         end
         OP_SYSTEM: begin
            // Only the CSR-immediate forms carry an immediate (zimm, unsigned).
            if (instr[14]) begin
               raw   = {27'b0, instr[19:15]};
               fmt_e = FMT_Z;
            end
         end
         default: begin
            raw   = '0;
            fmt_e = FMT_NONE;
         end
      endcase
   end

   // raw is already sign-correct at 32 bits; zimm has bit 31 clear, so one signed widening covers all formats.
   assign imm = WIDTH'($signed(raw));
   assign fmt = fmt_e;

   // R-type and every unknown opcode decode as NONE; SYSTEM and FENCE are legal without an immediate.
   assign illegal = (fmt_e == FMT_NONE) && (opcode != OP_SYSTEM) && (opcode != OP_FENCE);

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer and flush.
// Define IMM_ILLEGAL_FLAG_EN to register the unrecognised-opcode flag per result.
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_imm,
   output logic [2:0]       out_fmt,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   typedef struct packed {
      logic [WIDTH-1:0] imm;
      logic [2:0]       fmt;
      logic [TAG_W-1:0] tag;
   } entry_t;

   entry_t           dec;
   entry_t           main_q;
   entry_t           skid_q;
   logic [WIDTH-1:0] dec_imm;
   logic [2:0]       dec_fmt;
   logic             dec_illegal;
   logic             main_valid;
   logic             skid_valid;
   logic             accept;
   logic             load_main;
   logic             main_from_skid;
   logic             main_from_in;
   logic             skid_load;

   imm_extract #(.WIDTH(WIDTH)) u_extract (
      .instr   (in_instr),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_illegal)
   );

   assign dec = {dec_imm, dec_fmt, in_tag};

   // in_ready depends only on a flop, so out_ready never reaches it combinationally.
   assign in_ready = ~skid_valid;

   always_comb begin
      accept         = in_valid & in_ready;
      load_main      = ~main_valid | out_ready;
      main_from_skid = load_main & skid_valid;
      main_from_in   = load_main & ~skid_valid & accept;
      skid_load      = ~load_main & accept;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: payload registers are reset as well because out_imm/out_tag must read 0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         if (load_main) main_valid <= skid_valid | accept;
         if (main_from_skid)    main_q <= skid_q;
         else if (main_from_in) main_q <= dec;
         if (skid_load) begin
            skid_valid <= 1'b1;
            skid_q     <= dec;
         end else if (main_from_skid) begin
            skid_valid <= 1'b0;
         end
      end
   end

   assign out_valid = main_valid;
   assign out_imm   = main_q.imm;
   assign out_fmt   = main_q.fmt;
   assign out_tag   = main_q.tag;

`ifdef IMM_ILLEGAL_FLAG_EN
   logic main_ill;
   logic skid_ill;

   always_ff @(posedge clk) begin
      if (rst) begin
         main_ill <= 1'b0;
         skid_ill <= 1'b0;
      end else if (!flush) begin
         if (main_from_skid)    main_ill <= skid_ill;
         else if (main_from_in) main_ill <= dec_illegal;
         if (skid_load)         skid_ill <= dec_illegal;
      end
   end

   assign out_illegal = main_ill;
`else
   logic unused_illegal;
   assign unused_illegal = dec_illegal;
   assign out_illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: 32- and 64-bit instances share stimulus;
// a scoreboard queue holds expected results in acceptance order.
module tb_imm_decode_stage;

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic [31:0] tag;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_tag = '0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, out_illegal;
   logic [31:0] out_imm, out_tag;
   logic [2:0]  out_fmt;
   logic        in_ready_w, out_valid_w, out_illegal_w;
   logic [63:0] out_imm_w;
   logic [31:0] out_tag_w;
   logic [2:0]  out_fmt_w;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];
   exp_t cur_exp;

   always #5 clk = ~clk;

   imm_decode_stage #(.WIDTH(32), .TAG_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_fmt(out_fmt), .out_tag(out_tag), .out_illegal(out_illegal)
   );

   imm_decode_stage #(.WIDTH(64), .TAG_W(32)) dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_w), .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(out_valid_w), .out_ready(out_ready), .out_imm(out_imm_w),
      .out_fmt(out_fmt_w), .out_tag(out_tag_w), .out_illegal(out_illegal_w)
   );

   function automatic exp_t model(input logic [31:0] i, input logic [31:0] tag);
      exp_t e;
      logic signed [63:0] v;
      v = '0;
      e.fmt = 3'd0;
      case (i[6:0])
         7'h13, 7'h03, 7'h67: begin v = $signed(i[31:20]); e.fmt = 3'd1; end
         7'h23: begin v = $signed({i[31:25], i[11:7]}); e.fmt = 3'd2; end
         7'h63: begin v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); e.fmt = 3'd3; end
         7'h37, 7'h17: begin v = $signed({i[31:12], 12'h000}); e.fmt = 3'd4; end
         7'h6F: begin v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); e.fmt = 3'd5; end
         7'h73: if (i[14]) begin v = {59'b0, i[19:15]}; e.fmt = 3'd6; end
         default: v = '0;
      endcase
      e.imm = v;
      e.tag = tag;
`ifdef IMM_ILLEGAL_FLAG_EN
      e.ill = (e.fmt == 3'd0) && (i[6:0] != 7'h73) && (i[6:0] != 7'h0F);
`else
      e.ill = 1'b0;
`endif
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] instr, input logic [31:0] tag);
      in_valid = 1'b1;
      in_instr = instr;
      in_tag   = tag;
      cur_exp  = model(instr, tag);
      step();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, {63'b0, out_valid}, 64'd0);
      check({tag, "_in_ready"}, {63'b0, in_ready}, 64'd1);
      check({tag, "_out_imm"}, {32'b0, out_imm}, 64'd0);
      check({tag, "_out_imm64"}, out_imm_w, 64'd0);
      check({tag, "_out_fmt"}, {61'b0, out_fmt}, 64'd0);
      check({tag, "_out_tag"}, {32'b0, out_tag}, 64'd0);
      check({tag, "_out_illegal"}, {63'b0, out_illegal}, 64'd0);
   endtask

   // Scoreboard: compare on each output handshake, enqueue on each accepted input.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         n_checks++;
         assert (sb.size() != 0) else begin
            n_errors++;
            $error("FAIL unexpected_out: observed tag %h expected no output", out_tag);
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sb_imm32", {32'b0, out_imm}, {32'b0, e.imm[31:0]});
            check("sb_imm64", out_imm_w, e.imm);
            check("sb_fmt", {61'b0, out_fmt}, {61'b0, e.fmt});
            check("sb_fmt64", {61'b0, out_fmt_w}, {61'b0, e.fmt});
            check("sb_tag", {32'b0, out_tag}, {32'b0, e.tag});
            check("sb_ill", {63'b0, out_illegal}, {63'b0, e.ill});
         end
      end
      if (rst || flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(cur_exp);
   end

   logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                            7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h7F};

   initial begin
      logic [31:0] r;
      int          guard;

      repeat (2) step();
      check_reset_outputs("reset");
      rst = 1'b0;
      out_ready = 1'b1;

      // Directed formats, back-to-back at full throughput.
      send(32'hFFF00093, 32'h0);
      check("i_valid", {63'b0, out_valid}, 64'd1);
      check("i_imm", {32'b0, out_imm}, 64'h0000_0000_FFFF_FFFF);
      check("i_fmt", {61'b0, out_fmt}, 64'd1);
      send(32'hFE000EE3, 32'h100);
      check("b_imm", {32'b0, out_imm}, 64'h0000_0000_FFFF_FFFC);
      check("b_fmt", {61'b0, out_fmt}, 64'd3);
      check("b_tag", {32'b0, out_tag}, 64'h100);
      send(32'h800000B7, 32'h104);
      check("u_imm64", out_imm_w, 64'hFFFF_FFFF_8000_0000);
      send(32'h0000D073, 32'h108);
      check("z_imm64", out_imm_w, 64'h1);
      check("z_fmt", {61'b0, out_fmt_w}, 64'd6);
      send(32'h0000007F, 32'h10C);
      check("ill_imm", out_imm_w, 64'd0);
`ifdef IMM_ILLEGAL_FLAG_EN
      check("ill_flag", {63'b0, out_illegal}, 64'd1);
`else
      check("ill_flag", {63'b0, out_illegal}, 64'd0);
`endif
      send(32'hFE112E23, 32'h110);   // sw  x1,-4(x2)
      send(32'hFFDFF0EF, 32'h114);   // jal x1,-4
      send(32'h00000073, 32'h118);   // ecall
      send(32'h0FF0000F, 32'h11C);   // fence
      send(32'h00B50533, 32'h120);   // add
      send(32'h12345017, 32'h124);   // auipc
      idle(2);
      check("idle_valid", {63'b0, out_valid}, 64'd0);

      // Back-pressure: A then B with the consumer stalled for three cycles.
      out_ready = 1'b0;
      send(32'h00500113, 32'hA);
      check("bp_ready_a", {63'b0, in_ready}, 64'd1);
      send(32'h00600193, 32'hB);
      check("bp_ready_b", {63'b0, in_ready}, 64'd0);
      check("bp_hold_a", {32'b0, out_tag}, 64'hA);
      idle(1);
      check("bp_hold_a2", {32'b0, out_tag}, 64'hA);
      check("bp_hold_imm", {32'b0, out_imm}, 64'h5);
      check("bp_ready_c", {63'b0, in_ready}, 64'd0);
      out_ready = 1'b1;
      step();
      check("bp_b_tag", {32'b0, out_tag}, 64'hB);
      check("bp_b_valid", {63'b0, out_valid}, 64'd1);
      check("bp_ready_back", {63'b0, in_ready}, 64'd1);
      step();
      check("bp_drained", {63'b0, out_valid}, 64'd0);

      // Flush with both entries full, then with only main full and an acceptable input.
      out_ready = 1'b0;
      send(32'h00100093, 32'hBAD0);
      send(32'h00200093, 32'hBAD1);
      flush = 1'b1;
      send(32'h00300093, 32'hBAD2);
      flush = 1'b0;
      check("fl1_valid", {63'b0, out_valid}, 64'd0);
      check("fl1_ready", {63'b0, in_ready}, 64'd1);
      send(32'h00400093, 32'hBAD3);
      flush = 1'b1;
      send(32'h00500093, 32'hBAD4);
      flush = 1'b0;
      in_valid = 1'b0;
      check("fl2_valid", {63'b0, out_valid}, 64'd0);
      check("fl2_ready", {63'b0, in_ready}, 64'd1);
      out_ready = 1'b1;
      idle(3);
      check("fl_nothing", {63'b0, out_valid}, 64'd0);

      // Reset in the middle of a stall.
      out_ready = 1'b0;
      send(32'hFFF00093, 32'hC0);
      send(32'h800000B7, 32'hC1);
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_outputs("rst_mid");
      out_ready = 1'b1;
      idle(2);

      // Random traffic with random back-pressure.
      for (int k = 0; k < 300; k++) begin
         r = $urandom();
         in_valid  = ($urandom_range(3, 0) != 0);
         in_instr  = {r[31:7], ops[$urandom_range(11, 0)]};
         in_tag    = $urandom();
         cur_exp   = model(in_instr, in_tag);
         out_ready = ($urandom_range(2, 0) != 0);
         step();
      end

      in_valid  = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while ((sb.size() != 0 || out_valid) && guard < 20) begin
         step();
         guard++;
      end
      check("drain_queue", 64'(sb.size()), 64'd0);
      check("drain_valid", {63'b0, out_valid}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered immediate-generation stage for the pipelined RISC-V core, sitting between the IF/ID instruction register and the ID/EX operand path. Each cycle it accepts one instruction word plus a pass-through tag (normally the PC), decodes the instruction format, and produces the extended immediate one cycle later. Immediates are sign-extended to a parametrised XLEN. A 2-entry skid buffer gives a full-throughput valid/ready handshake with synchronous flush for branch redirects.

## Interface
- `WIDTH`, default 32: XLEN of the immediate output (32 or 64).
- `TAG_W`, default 32: width of the pass-through tag.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `flush`, input, 1: synchronous discard of all buffered entries.
- `in_valid`, input, 1: instruction present.
- `in_ready`, output, 1: stage can accept.
- `in_instr`, input, 32: instruction word.
- `in_tag`, input, TAG_W: tag, carried unchanged.
- `out_valid`, output, 1: result present.
- `out_ready`, input, 1: consumer accepts.
- `out_imm`, output, WIDTH: extended immediate.
- `out_fmt`, output, 3: `imm_fmt_e` format code.
- `out_tag`, output, TAG_W: tag of the result.
- `out_illegal`, output, 1: opcode not recognised (see Configuration).

## Operation
- Format by `instr[6:0]`:
  - `0010011`, `0000011`, `1100111` (JALR): I, sign-extend `instr[31:20]`.
  - `0100011`: S, `{instr[31:25], instr[11:7]}`, sign-extended.
  - `1100011`: B, `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`, sign-extended.
  - `0110111`, `0010111`: U, `{instr[31:12], 12'b0}`, sign-extended from bit 31 to WIDTH.
  - `1101111`: J, `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`, sign-extended.
  - `1110011` with `funct3[2]=1`: Z, zero-extend `instr[19:15]` (CSR zimm). Other SYSTEM encodings: NONE.
  - Any other opcode: NONE, imm = 0.
- Storage is a main output register plus one skid register. `in_ready` is the inverse of `skid_valid`, registered, so there is no combinational path from `out_ready` to `in_ready`.
- When an instruction is accepted (`in_valid & in_ready`):
  - It goes to the main register if the main register is empty or draining this cycle (`out_ready`).
  - Otherwise it goes to the skid register.
- When the main register drains and the skid register is full, the skid entry moves into the main register.
- Order of results is strictly FIFO.

## Timing
- Latency: an instruction accepted at edge N gives `out_valid` = 1 with its result after edge N.
- Throughput: 1 instruction per cycle while `out_ready` = 1.
- Output stability: outputs are held stable while `out_valid & !out_ready`.
- Back-pressure:
  - `in_ready` falls in the cycle after the skid register fills.
  - It rises in the cycle after the skid register empties.
- Flush:
  - At the edge where `flush` = 1, both entries are invalidated. Any simultaneous accept is dropped, because flush has priority.
  - After the edge, `out_valid` = 0 and `in_ready` = 1.
- Reset, also mid-operation, has priority over flush:
  - `out_valid` = 0, `in_ready` = 1.
  - `out_imm` = 0, `out_fmt` = NONE, `out_tag` = 0, `out_illegal` = 0.
  - Skid register cleared.
- Simultaneous drain and accept with the skid register empty: the main register is replaced in the same edge, with no bubble.

## Configuration
- Macro: `IMM_ILLEGAL_FLAG_EN`.
- When defined, `out_illegal` is registered alongside each result. It is 1 for NONE-format opcodes other than the defined SYSTEM/FENCE encodings (`1110011`, `0001111`) and for `0110011` (R-type). Otherwise it is 0.
- When undefined, `out_illegal` is tied to 0 and no storage bit exists.

## Structure
- Package `imm_pkg`:
  - opcode constants (`OP_IMM`, `OP_LOAD`, `OP_JALR`, `OP_STORE`, `OP_BRANCH`, `OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_SYSTEM`, `OP_REG`, `OP_FENCE`);
  - enum `imm_fmt_e` (NONE, I, S, B, U, J, Z), 3 bits.
- Sub-module `imm_extract`: combinational format decode and extension, parametrised by WIDTH, with an illegal-flag output. The top level holds only the skid/handshake logic and is instantiated once.

## Test plan
- I-type, WIDTH=32: `in_instr` 0xFFF00093 (addi x1,x0,-1) -> next cycle `out_imm` 0xFFFFFFFF, fmt I.
- B-type: `in_instr` 0xFE000EE3 (beq -4) -> `out_imm` 0xFFFFFFFC, fmt B. Tag 0x100 -> `out_tag` 0x100.
- U-type and CSR, WIDTH=64:
  - 0x800000B7 (lui) -> `out_imm` 0xFFFFFFFF80000000;
  - 0x0000D073 (zimm=1) -> `out_imm` 0x1, fmt Z.
- Back-pressure:
  - Setup: `out_ready` = 0 for 3 cycles while A and B are sent back-to-back.
  - Required: `in_ready` = 0 after B; A is held on the outputs.
  - After `out_ready` = 1, A then B appear on consecutive cycles and `in_ready` returns to 1.
- Flush:
  - Setup: main and skid registers full, then `flush` = 1 with `in_valid` = 1.
  - Required: next cycle `out_valid` = 0, `in_ready` = 1, and the flushed inputs never appear.
- Reset and illegal flag:
  - `rst` mid-stall -> all outputs at reset values.
  - Opcode 0x7F -> `out_illegal` = 1 with `IMM_ILLEGAL_FLAG_EN` defined and 0 without; `out_imm` = 0 in both cases.
